hd_transfer_controller: RTL and testbench

- Block-transfer engine directly upstream of the hard-drive storage array.
- Moves a run of 32-bit words between the hard drive and main data memory, in either direction, one word per clock.
- Generates the drive's track/sector address, write data and write flag, so the OS can load program images from disk and save memory back to disk.

---
 rtl/hd_pkg.sv | 26 ++
 rtl/hd_address_counter.sv | 53 +++++
 rtl/hd_transfer_controller.sv | 144 ++++++++++++++
 tb/tb_hd_transfer_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// Shared types and constants for the hard-drive block-transfer engine.
package hd_pkg;

    localparam int unsigned TRACK_W        = 7;
    localparam int unsigned SECTOR_W       = 14;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned DEF_MEM_AW     = 10;
    localparam int unsigned DEF_COUNT_W    = 16;
    localparam int unsigned DEF_SECTOR_MAX = 16383;
    localparam int unsigned DEF_TRACK_MAX  = 127;

    localparam logic DIR_HD_TO_MEM = 1'b0;
    localparam logic DIR_MEM_TO_HD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [TRACK_W-1:0]  track;
        logic [SECTOR_W-1:0] sector;
    } hd_addr_t;

endpackage

// File: rtl/hd_address_counter.sv
// Track/sector pointer: load, per-word increment with sector wrap into the
// next track, and a flag for the wrap that would run past the last track.
module hd_address_counter
    import hd_pkg::*;
#(
    parameter int unsigned SECTOR_MAX = DEF_SECTOR_MAX,
    parameter int unsigned TRACK_MAX  = DEF_TRACK_MAX
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [TRACK_W-1:0]  load_track_i,
    input  logic [SECTOR_W-1:0] load_sector_i,
    input  logic                inc_i,
    output logic [TRACK_W-1:0]  track_o,
    output logic [SECTOR_W-1:0] sector_o,
    output logic                overflow_c
);

    hd_addr_t addr_q, addr_d;
    logic     sector_wrap_c;

    assign sector_wrap_c = (addr_q.sector == SECTOR_W'(SECTOR_MAX));
    assign overflow_c    = sector_wrap_c && (addr_q.track == TRACK_W'(TRACK_MAX));

    // An increment at the overflow point holds the pointer; the engine stops there.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d.track  = load_track_i;
            addr_d.sector = load_sector_i;
        end else if (inc_i && !overflow_c) begin
            if (sector_wrap_c) begin
                addr_d.sector = '0;
                addr_d.track  = addr_q.track + TRACK_W'(1);
            end else begin
                addr_d.sector = addr_q.sector + SECTOR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign track_o  = addr_q.track;
    assign sector_o = addr_q.sector;

endmodule

// File: rtl/hd_transfer_controller.sv
// Block-transfer engine moving a run of words between the hard drive and
// main memory, one word per clock, in either direction.
module hd_transfer_controller
    import hd_pkg::*;
#(
    parameter int unsigned MEM_AW     = DEF_MEM_AW,
    parameter int unsigned COUNT_W    = DEF_COUNT_W,
    parameter int unsigned SECTOR_MAX = DEF_SECTOR_MAX,
    parameter int unsigned TRACK_MAX  = DEF_TRACK_MAX
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                direction,
    input  logic [TRACK_W-1:0]  start_track,
    input  logic [SECTOR_W-1:0] start_sector,
    input  logic [MEM_AW-1:0]   mem_base,
    input  logic [COUNT_W-1:0]  word_count,
    input  logic                abort,
    output logic [TRACK_W-1:0]  hd_track,
    output logic [SECTOR_W-1:0] hd_sector,
    output logic [DATA_W-1:0]   hd_data_write,
    output logic                flag_write_hd,
    input  logic [DATA_W-1:0]   hd_data_read,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data_write,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_data_read,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [COUNT_W-1:0]  words_done
);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
    logic [COUNT_W-1:0] words_done_q, words_done_d;
    logic               error_q, error_d;

    logic               load_c;
    logic               inc_c;
    logic               overflow_c;
    logic [COUNT_W-1:0] words_next_c;
    logic               xfer_ok_c;

    hd_address_counter #(
        .SECTOR_MAX (SECTOR_MAX),
        .TRACK_MAX  (TRACK_MAX)
    ) u_addr (
        .clk_i         (clock),
        .rst_ni        (reset_n),
        .load_i        (load_c),
        .load_track_i  (start_track),
        .load_sector_i (start_sector),
        .inc_i         (inc_c),
        .track_o       (hd_track),
        .sector_o      (hd_sector),
        .overflow_c    (overflow_c)
    );

    assign words_next_c = words_done_q + COUNT_W'(1);

    // Next-state and per-word advance.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        count_d      = count_q;
        mem_addr_d   = mem_addr_q;
        words_done_d = words_done_q;
        error_d      = error_q;
        load_c       = 1'b0;
        inc_c        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d        = direction;
                    count_d      = word_count;
                    mem_addr_d   = mem_base;
                    words_done_d = '0;
                    error_d      = 1'b0;
                    load_c       = 1'b1;
                    state_d      = (word_count != '0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    inc_c        = 1'b1;
                    mem_addr_d   = mem_addr_q + MEM_AW'(1);
                    words_done_d = words_next_c;
                    if (words_next_c == count_q) begin
                        state_d = ST_DONE;
                    end else if (overflow_c) begin
                        // Last addressable sector written with words still pending.
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_HD_TO_MEM;
            count_q      <= '0;
            mem_addr_q   <= '0;
            words_done_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            words_done_q <= words_done_d;
            error_q      <= error_d;
        end
    end

    // Strobes and write data pass through in the same cycle, gated by abort.
    assign xfer_ok_c      = (state_q == ST_XFER) && !abort;
    assign mem_write      = xfer_ok_c && (dir_q == DIR_HD_TO_MEM);
    assign flag_write_hd  = xfer_ok_c && (dir_q == DIR_MEM_TO_HD);
    assign mem_data_write = mem_write ? hd_data_read : '0;
    assign hd_data_write  = flag_write_hd ? mem_data_read : '0;

    assign busy       = (state_q == ST_XFER);
    assign done       = (state_q == ST_DONE);
    assign error      = error_q;
    assign mem_addr   = mem_addr_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_hd_transfer_controller.sv
// Bench for hd_transfer_controller: drive and memory models, write logger,
// directed table plus randomized transfers against an arithmetic model.
module tb_hd_transfer_controller;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        direction;
    logic [6:0]  start_track;
    logic [13:0] start_sector;
    logic [9:0]  mem_base;
    logic [15:0] word_count;
    logic        abort;
    logic [6:0]  hd_track;
    logic [13:0] hd_sector;
    logic [31:0] hd_data_write;
    logic        flag_write_hd;
    logic [31:0] hd_data_read;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data_write;
    logic        mem_write;
    logic [31:0] mem_data_read;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;

    hd_transfer_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .direction      (direction),
        .start_track    (start_track),
        .start_sector   (start_sector),
        .mem_base       (mem_base),
        .word_count     (word_count),
        .abort          (abort),
        .hd_track       (hd_track),
        .hd_sector      (hd_sector),
        .hd_data_write  (hd_data_write),
        .flag_write_hd  (flag_write_hd),
        .hd_data_read   (hd_data_read),
        .mem_addr       (mem_addr),
        .mem_data_write (mem_data_write),
        .mem_write      (mem_write),
        .mem_data_read  (mem_data_read),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_done     (words_done)
    );

    localparam int DISK_WORDS = 128 * 16384;

    logic [31:0] hd_mem [0:DISK_WORDS-1];
    logic [31:0] mem    [0:1023];

    assign hd_data_read  = hd_mem[{hd_track, hd_sector}];
    assign mem_data_read = mem[mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        hd_w;
        logic        mem_w;
        logic [6:0]  trk;
        logic [13:0] sec;
        logic [9:0]  ma;
        logic [31:0] hdd;
        logic [31:0] memd;
    } wr_t;

    wr_t wlog[$];
    int  stray = 0;

    // Log every strobed cycle; strobes outside XFER or both at once are stray.
    always @(negedge clock) begin
        if (flag_write_hd || mem_write) begin
            wlog.push_back('{flag_write_hd, mem_write, hd_track, hd_sector, mem_addr,
                             hd_data_write, mem_data_write});
            if (!busy) stray = stray + 1;
            if (flag_write_hd && mem_write) stray = stray + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: disk is one linear run of 128*16384 words; writes stop at
    // the first of count, end of disk, or the abort cycle.
    function automatic void model(input int trk, input int sec, input int cnt, input int ab,
                                  output int nw, output int err, output int dc);
        int avail;
        int m;
        bit aborted;
        avail   = DISK_WORDS - (trk * 16384 + sec);
        m       = (cnt < avail) ? cnt : avail;
        aborted = (ab >= 0) && (ab < m);
        nw      = aborted ? ab : m;
        err     = (!aborted && cnt > avail) ? 1 : 0;
        dc      = nw + (aborted ? 1 : 0);
    endfunction

    task automatic run_xfer(input logic d, input int trk, input int sec, input int base,
                            input int cnt, input int abort_at, input int restart_at,
                            input int exp_words, input int exp_err, input int exp_dc);
        int l0;
        int lin;
        int dc;
        int nlog;
        lin = trk * 16384 + sec;
        dc  = -1;
        l0  = wlog.size();
        @(posedge clock); #1;
        direction    = d;
        start_track  = 7'(trk);
        start_sector = 14'(sec);
        mem_base     = 10'(base);
        word_count   = 16'(cnt);
        start        = 1'b1;
        @(posedge clock); #1;
        start        = 1'b0;
        direction    = ~d;
        start_track  = ~start_track;
        start_sector = ~start_sector;
        mem_base     = ~mem_base;
        word_count   = word_count + 16'd7;
        for (int c = 0; c < 300; c++) begin
            abort = (c == abort_at);
            if (c == restart_at) start = 1'b1;
            @(negedge clock);
            if (done) begin
                dc = c;
                break;
            end
            chk("busy_in_xfer", 64'(busy), 64'd1);
            @(posedge clock); #1;
            start = 1'b0;
        end
        chk("done_cycle", 64'(dc), 64'(exp_dc));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("words_done", 64'(words_done), 64'(exp_words));
        chk("error", 64'(error), 64'(exp_err));
        nlog = wlog.size() - l0;
        chk("write_count", 64'(nlog), 64'(exp_words));
        for (int k = 0; k < nlog && k < exp_words; k++) begin
            wr_t         w;
            int          p;
            int          ma;
            logic [31:0] ed;
            w  = wlog[l0 + k];
            p  = lin + k;
            ma = (base + k) % 1024;
            ed = d ? mem[ma] : hd_mem[p];
            chk("write_addr", {31'b0, w.hd_w, w.mem_w, w.trk, w.sec, w.ma},
                {31'b0, d, ~d, 7'(p / 16384), 14'(p % 16384), 10'(ma)});
            chk("write_data", {w.hdd, w.memd}, d ? {ed, 32'h0} : {32'h0, ed});
        end
        for (int k = 0; k < nlog; k++) begin
            if (wlog[l0 + k].hd_w)  hd_mem[{wlog[l0 + k].trk, wlog[l0 + k].sec}] = wlog[l0 + k].hdd;
            if (wlog[l0 + k].mem_w) mem[wlog[l0 + k].ma] = wlog[l0 + k].memd;
        end
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        chk("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    typedef struct {
        logic d;
        int   trk;
        int   sec;
        int   base;
        int   cnt;
        int   ab;
        int   rs;
        int   ew;
        int   ee;
        int   edc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int l0;
        reset_n      = 1'b0;
        start        = 1'b0;
        direction    = 1'b0;
        start_track  = '0;
        start_sector = '0;
        mem_base     = '0;
        word_count   = '0;
        abort        = 1'b0;

        // Directed vectors: {dir, track, sector, base, count, abort_at, restart_at,
        //                    words, error, done_cycle}
        tbl.push_back('{1'b0,   2,     5, 'h010,  4, -1, -1, 4, 0, 4});
        tbl.push_back('{1'b1,   0,     0, 'h000,  3, -1, -1, 3, 0, 3});
        tbl.push_back('{1'b0,   3, 16383, 'h020,  2, -1, -1, 2, 0, 2});
        tbl.push_back('{1'b1, 127, 16383, 'h030,  3, -1, -1, 1, 1, 1});
        tbl.push_back('{1'b0,   9,     9, 'h040,  0, -1, -1, 0, 0, 0});
        tbl.push_back('{1'b0,   5,   100, 'h3FE, 10,  3, -1, 3, 0, 4});
        tbl.push_back('{1'b1, 127, 16382, 'h050,  2, -1, -1, 2, 0, 2});
        tbl.push_back('{1'b0, 127, 16383, 'h060,  3,  1, -1, 1, 1, 1});
        tbl.push_back('{1'b1, 126, 16383, 'h070,  2,  0, -1, 0, 0, 1});
        tbl.push_back('{1'b0,  10,     0, 'h100,  5, -1,  2, 5, 0, 5});
        tbl.push_back('{1'b1,   0,     0, 'h000,  3, -1,  3, 3, 0, 3});

        for (int i = 0; i < 4; i++) hd_mem[2 * 16384 + 5 + i] = 32'hA0 + 32'(i);
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_addr", {30'b0, hd_track, hd_sector, mem_addr}, 64'd0);
        chk("reset_ctl", 64'({busy, done, error, flag_write_hd, mem_write}), 64'd0);
        chk("reset_data", {hd_data_write, mem_data_write}, 64'd0);
        chk("reset_words", 64'(words_done), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_xfer(tbl[i].d, tbl[i].trk, tbl[i].sec, tbl[i].base, tbl[i].cnt,
                     tbl[i].ab, tbl[i].rs, tbl[i].ew, tbl[i].ee, tbl[i].edc);
            if (i == 0) begin
                for (int k = 0; k < 4; k++) chk("hd2mem_copy", 64'(mem['h10 + k]), 64'(32'hA0 + k));
            end
            if (i == 1) begin
                chk("mem2hd_s0", 64'(hd_mem[0]), 64'h11);
                chk("mem2hd_s1", 64'(hd_mem[1]), 64'h22);
                chk("mem2hd_s2", 64'(hd_mem[2]), 64'h33);
            end
        end

        // Reset in the middle of a transfer.
        @(posedge clock); #1;
        direction    = 1'b1;
        start_track  = 7'd20;
        start_sector = 14'd0;
        mem_base     = 10'h5;
        word_count   = 16'd10;
        start        = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        l0      = wlog.size();
        reset_n = 1'b0;
        #1;
        chk("async_rst_ctl", 64'({busy, done, error, flag_write_hd, mem_write}), 64'd0);
        chk("async_rst_addr", {30'b0, hd_track, hd_sector, mem_addr}, 64'd0);
        chk("async_rst_data", {hd_data_write, mem_data_write}, 64'd0);
        chk("async_rst_words", 64'(words_done), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("no_write_after_reset", 64'(wlog.size() - l0), 64'd0);
        chk("idle_after_reset", 64'(busy), 64'd0);

        for (int r = 0; r < 40; r++) begin
            logic d;
            int   trk;
            int   sec;
            int   base;
            int   cnt;
            int   ab;
            int   lin;
            int   nw;
            int   ee;
            int   edc;
            d    = 1'($urandom_range(0, 1));
            trk  = ($urandom_range(0, 1) == 1) ? 127 : int'($urandom_range(0, 127));
            sec  = ($urandom_range(0, 1) == 1) ? 16383 - int'($urandom_range(0, 3))
                                               : int'($urandom_range(0, 16383));
            base = int'($urandom_range(0, 1023));
            cnt  = int'($urandom_range(0, 12));
            ab   = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 12));
            lin  = trk * 16384 + sec;
            for (int k = 0; k < cnt; k++) begin
                if (d) mem[(base + k) % 1024] = $urandom;
                else if (lin + k < DISK_WORDS) hd_mem[lin + k] = $urandom;
            end
            model(trk, sec, cnt, ab, nw, ee, edc);
            run_xfer(d, trk, sec, base, cnt, ab, -1, nw, ee, edc);
        end

        chk("strobe_outside_xfer", 64'(stray), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
